acq_seq: RTL and testbench

- Segmented-acquisition sequencer that drives the control inputs of one acquire (start/trigger/stop) stream block.
- Runs cfg_seg back-to-back acquisitions (0 = endless). Each run is separated by cfg_hld holdoff cycles.
- Provides segment count, timestamps, abort and a done interrupt.
- Sits between the register bank and the acquire block, in the acquire block's clock domain.

---
 rtl/acq_seq_if.sv | 33 +++
 rtl/acq_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_acq_seq.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acq_seq_if.sv
// acq_seq_if
//   Control link between the segmented-acquisition sequencer and the
//   acquire stream block it drives.
//
//   Signals:
//     acq_rst      sequencer -> acquire  clear acquire block (ctl_rst)
//     acq_acq      sequencer -> acquire  arm one acquisition (ctl_acq)
//     acq_stp      sequencer -> acquire  force stop (ctl_stp)
//     acq_irq_stp  acquire -> sequencer  acquisition finished (irq_stp)
//
//   Modports:
//     master  the sequencer side
//     slave   the acquire block side
interface acq_seq_if;
  logic acq_rst;
  logic acq_acq;
  logic acq_stp;
  logic acq_irq_stp;

  modport master (
    output acq_rst,
    output acq_acq,
    output acq_stp,
    input  acq_irq_stp
  );

  modport slave (
    input  acq_rst,
    input  acq_acq,
    input  acq_stp,
    output acq_irq_stp
  );
endinterface

// File: rtl/acq_seq.sv
// acq_seq
//   Segmented-acquisition sequencer. Runs cfg_seg back-to-back acquisitions
//   (0 = endless) on one acquire block, separated by cfg_hld holdoff cycles,
//   and reports segment count, start/end timestamps, abort status and a
//   done interrupt. Lives in the acquire block's clock domain.
//
//   Optional feature macro: ACQ_SEQ_TMO_EN
//     When defined, a per-segment timeout (cfg_tmo cycles in WAIT) pulses
//     acq_stp and sets the sticky sts_tmo output.
//
//   Ports:
//     ACLK, ARESET  clock, synchronous active-high reset
//     cts           current timestamp
//     ctl_str       start sequence pulse
//     ctl_abt       abort sequence pulse
//     cfg_seg       segments per sequence, 0 = infinite
//     cfg_hld       holdoff cycles between segments
//     cfg_tmo       per-segment timeout (timeout build only)
//     acq           control link to the acquire block (master side)
//     sts_run       sequence active
//     sts_seg       completed segments (saturating)
//     sts_abt       sticky: last sequence aborted
//     cts_str       timestamp of last accepted start
//     cts_end       timestamp of sequence end (done or abort)
//     irq_don       one-cycle pulse on normal completion
//     sts_tmo       sticky timeout flag (timeout build only)
module acq_seq #(
  parameter int SW = 16,
  parameter int HW = 32,
  parameter int TW = 32
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic [TW-1:0] cts,
  input  logic          ctl_str,
  input  logic          ctl_abt,
  input  logic [SW-1:0] cfg_seg,
  input  logic [HW-1:0] cfg_hld,
  input  logic [HW-1:0] cfg_tmo,
  acq_seq_if.master     acq,
  output logic          sts_run,
  output logic [SW-1:0] sts_seg,
  output logic          sts_abt,
  output logic [TW-1:0] cts_str,
  output logic [TW-1:0] cts_end,
  output logic          irq_don
`ifdef ACQ_SEQ_TMO_EN
  ,
  output logic          sts_tmo
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ARM,
    S_WAIT,
    S_HOLD,
    S_ABT
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] seg_q, seg_d;
  logic          abt_q, abt_d;
  logic [TW-1:0] ctsStr_q, ctsStr_d;
  logic [TW-1:0] ctsEnd_q, ctsEnd_d;
  logic [HW-1:0] hld_q, hld_d;
  logic          don_q, don_d;

  // One bit wider than the segment counter so an all-ones count can never
  // alias onto a small cfg_seg after wrapping.
  logic [SW:0]   segInc;
  assign segInc = {1'b0, seg_q} + (SW+1)'(1);

`ifdef ACQ_SEQ_TMO_EN
  logic [HW-1:0] tmoCnt_q, tmoCnt_d;
  logic          tmoPls_q, tmoPls_d;
  logic          stsTmo_q, stsTmo_d;
`else
  logic          unusedTmo;
  assign unusedTmo = ^cfg_tmo;
`endif

  // State and status registers; reset returns straight to IDLE without
  // issuing a stop because the acquire block is reset alongside us.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= S_IDLE;
      seg_q    <= '0;
      abt_q    <= 1'b0;
      ctsStr_q <= '0;
      ctsEnd_q <= '0;
      hld_q    <= '0;
      don_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      abt_q    <= abt_d;
      ctsStr_q <= ctsStr_d;
      ctsEnd_q <= ctsEnd_d;
      hld_q    <= hld_d;
      don_q    <= don_d;
    end
  end

`ifdef ACQ_SEQ_TMO_EN
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      tmoCnt_q <= '0;
      tmoPls_q <= 1'b0;
      stsTmo_q <= 1'b0;
    end else begin
      tmoCnt_q <= tmoCnt_d;
      tmoPls_q <= tmoPls_d;
      stsTmo_q <= stsTmo_d;
    end
  end
`endif

  // Next-state logic. Abort outranks everything outside IDLE, including a
  // coincident segment end, so that segment is not counted.
  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    abt_d    = abt_q;
    ctsStr_d = ctsStr_q;
    ctsEnd_d = ctsEnd_q;
    hld_d    = hld_q;
    don_d    = 1'b0;
`ifdef ACQ_SEQ_TMO_EN
    tmoCnt_d = tmoCnt_q;
    tmoPls_d = 1'b0;
    stsTmo_d = stsTmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (ctl_str && !ctl_abt) begin
          state_d  = S_CLR;
          seg_d    = '0;
          abt_d    = 1'b0;
          ctsStr_d = cts;
`ifdef ACQ_SEQ_TMO_EN
          stsTmo_d = 1'b0;
`endif
        end
      end

      S_ABT: begin
        state_d  = S_IDLE;
        abt_d    = 1'b1;
        ctsEnd_d = cts;
      end

      default: begin
        if (ctl_abt) begin
          state_d = S_ABT;
        end else begin
          case (state_q)
            S_CLR: state_d = S_ARM;

            S_ARM: begin
              state_d = S_WAIT;
`ifdef ACQ_SEQ_TMO_EN
              tmoCnt_d = '0;
`endif
            end

            S_WAIT: begin
              if (acq.acq_irq_stp) begin
                seg_d = (&seg_q) ? seg_q : segInc[SW-1:0];
                if ((cfg_seg != '0) && (segInc == {1'b0, cfg_seg})) begin
                  state_d  = S_IDLE;
                  don_d    = 1'b1;
                  ctsEnd_d = cts;
                end else if (cfg_hld == '0) begin
                  state_d = S_ARM;
                end else begin
                  state_d = S_HOLD;
                  hld_d   = '0;
                end
              end
`ifdef ACQ_SEQ_TMO_EN
              else begin
                // Stay in WAIT after the forced stop; the echoed irq_stp
                // then ends the segment through the normal path.
                tmoCnt_d = tmoCnt_q + HW'(1);
                if ((cfg_tmo != '0) && (tmoCnt_q == cfg_tmo - HW'(1))) begin
                  tmoPls_d = 1'b1;
                  stsTmo_d = 1'b1;
                end
              end
`endif
            end

            S_HOLD: begin
              // Counter runs 0..cfg_hld-1, giving exactly cfg_hld HOLD cycles.
              hld_d = hld_q + HW'(1);
              if (hld_q == cfg_hld - HW'(1)) begin
                state_d = S_ARM;
              end
            end

            default: ;
          endcase
        end
      end
    endcase
  end

  assign acq.acq_rst = (state_q == S_CLR);
  assign acq.acq_acq = (state_q == S_ARM);
`ifdef ACQ_SEQ_TMO_EN
  assign acq.acq_stp = (state_q == S_ABT) | tmoPls_q;
  assign sts_tmo     = stsTmo_q;
`else
  assign acq.acq_stp = (state_q == S_ABT);
`endif

  assign sts_run = (state_q != S_IDLE);
  assign sts_seg = seg_q;
  assign sts_abt = abt_q;
  assign cts_str = ctsStr_q;
  assign cts_end = ctsEnd_q;
  assign irq_don = don_q;

endmodule

// File: tb/tb_acq_seq.sv
// tb_acq_seq
//   Directed bench for acq_seq. The acquire block is played inline by the
//   stimulus sequence, which returns acq_irq_stp at chosen cycles.
module tb_acq_seq;
  localparam int SW = 16;
  localparam int HW = 32;
  localparam int TW = 32;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [TW-1:0] cts;
  logic          ctl_str;
  logic          ctl_abt;
  logic [SW-1:0] cfg_seg;
  logic [HW-1:0] cfg_hld;
  logic [HW-1:0] cfg_tmo;
  logic          sts_run;
  logic [SW-1:0] sts_seg;
  logic          sts_abt;
  logic [TW-1:0] cts_str;
  logic [TW-1:0] cts_end;
  logic          irq_don;
`ifdef ACQ_SEQ_TMO_EN
  logic          sts_tmo;
`endif

  int testsRun  = 0;
  int failCount = 0;
  int donCount  = 0;
  int acqCount  = 0;

  acq_seq_if ifc ();

  acq_seq #(.SW(SW), .HW(HW), .TW(TW)) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .cts     (cts),
    .ctl_str (ctl_str),
    .ctl_abt (ctl_abt),
    .cfg_seg (cfg_seg),
    .cfg_hld (cfg_hld),
    .cfg_tmo (cfg_tmo),
    .acq     (ifc),
    .sts_run (sts_run),
    .sts_seg (sts_seg),
    .sts_abt (sts_abt),
    .cts_str (cts_str),
    .cts_end (cts_end),
    .irq_don (irq_don)
`ifdef ACQ_SEQ_TMO_EN
    ,
    .sts_tmo (sts_tmo)
`endif
  );

  always #5 ACLK = ~ACLK;

  // Advance one clock; outputs are sampled 1 ns after the edge and the
  // timestamp moves on so each cycle has a distinct cts value.
  task automatic tick();
    @(posedge ACLK);
    #1;
    cts = cts + 1;
    if (irq_don === 1'b1) donCount++;
    if (ifc.acq_acq === 1'b1) acqCount++;
  endtask

  // Hold the given control inputs across one clock edge, then clear them.
  task automatic applyStimulus(input logic str, input logic abt, input logic stp);
    ctl_str         = str;
    ctl_abt         = abt;
    ifc.acq_irq_stp = stp;
    tick();
    ctl_str         = 1'b0;
    ctl_abt         = 1'b0;
    ifc.acq_irq_stp = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step until acq_acq is seen; n is the number of clocks it took.
  task automatic waitAcq(output int n);
    n = 0;
    while (ifc.acq_acq !== 1'b1 && n < 100) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (n >= 100) checkOutput("acq_wait_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [TW-1:0] cStart;
    logic [TW-1:0] cEnd;
    logic [TW-1:0] c6;
    int            n;
    int            d0;
    int            a0;
    int            maxGap;

    cts             = 32'h0000_1000;
    ctl_str         = 1'b0;
    ctl_abt         = 1'b0;
    ifc.acq_irq_stp = 1'b0;
    cfg_seg         = '0;
    cfg_hld         = '0;
    cfg_tmo         = '0;
    ARESET          = 1'b1;
    idle(2);
    ARESET          = 1'b0;

    // Reset state
    checkOutput("rst_run", sts_run, 0);
    checkOutput("rst_acq_rst", ifc.acq_rst, 0);
    checkOutput("rst_acq_acq", ifc.acq_acq, 0);
    checkOutput("rst_acq_stp", ifc.acq_stp, 0);
    checkOutput("rst_seg", sts_seg, 0);
    checkOutput("rst_abt", sts_abt, 0);
    checkOutput("rst_cts_str", cts_str, 0);
    checkOutput("rst_cts_end", cts_end, 0);
    checkOutput("rst_irq_don", irq_don, 0);

    // Start latency with a single segment
    cfg_seg = 16'd1;
    cfg_hld = 32'd0;
    cStart  = cts;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("lat_k1_rst", ifc.acq_rst, 1);
    checkOutput("lat_k1_acq", ifc.acq_acq, 0);
    checkOutput("lat_k1_run", sts_run, 1);
    checkOutput("lat_cts_str", cts_str, cStart);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lat_k2_rst", ifc.acq_rst, 0);
    checkOutput("lat_k2_acq", ifc.acq_acq, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lat_k3_acq", ifc.acq_acq, 0);
    idle(3);
    cEnd = cts;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("one_irq_don", irq_don, 1);
    checkOutput("one_seg", sts_seg, 1);
    checkOutput("one_run", sts_run, 0);
    checkOutput("one_cts_end", cts_end, cEnd);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("one_irq_don_pulse", irq_don, 0);

    // Three segments with a holdoff of 4, stop 10 cycles after each arm
    cfg_seg = 16'd3;
    cfg_hld = 32'd4;
    cStart  = cts;
    d0      = donCount;
    a0      = acqCount;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int seg = 0; seg < 3; seg++) begin
      waitAcq(n);
      if (seg > 0) checkOutput("hld_gap", n, 4);
      idle(9);
      cEnd = cts;
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (seg < 2) checkOutput("hld_seg_mid", sts_seg, seg + 1);
    end
    checkOutput("hld_irq_don", irq_don, 1);
    checkOutput("hld_seg", sts_seg, 3);
    checkOutput("hld_cts_end", cts_end, cEnd);
    checkOutput("hld_cts_str", cts_str, cStart);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("hld_run_after", sts_run, 0);
    checkOutput("hld_acq_pulses", acqCount - a0, 3);
    checkOutput("hld_don_count", donCount - d0, 1);

    // Endless mode, no holdoff, 20 segments then abort from ARM
    cfg_seg = 16'd0;
    cfg_hld = 32'd0;
    d0      = donCount;
    maxGap  = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitAcq(n);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        waitAcq(n);
        if (n > maxGap) maxGap = n;
      end
      idle(4);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("inf_gap", maxGap, 0);
    checkOutput("inf_seg", sts_seg, 20);
    checkOutput("inf_arm", ifc.acq_acq, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("inf_abt_stp", ifc.acq_stp, 1);
    checkOutput("inf_abt_acq", ifc.acq_acq, 0);
    checkOutput("inf_abt_run", sts_run, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("inf_stp_pulse", ifc.acq_stp, 0);
    checkOutput("inf_run", sts_run, 0);
    checkOutput("inf_sts_abt", sts_abt, 1);
    checkOutput("inf_seg_end", sts_seg, 20);
    checkOutput("inf_no_don", donCount - d0, 0);

    // Abort coincident with the stop of segment 2 of 5
    cfg_seg = 16'd5;
    cfg_hld = 32'd0;
    cStart  = cts;
    d0      = donCount;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("co_abt_cleared", sts_abt, 0);
    waitAcq(n);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("co_seg1", sts_seg, 1);
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("co_abt_stp", ifc.acq_stp, 1);
    checkOutput("co_abt_seg", sts_seg, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("co_run", sts_run, 0);
    checkOutput("co_seg", sts_seg, 1);
    checkOutput("co_sts_abt", sts_abt, 1);
    checkOutput("co_no_don", donCount - d0, 0);

    // Start with abort in IDLE is ignored
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("sa_run", sts_run, 0);
    checkOutput("sa_acq_rst", ifc.acq_rst, 0);
    checkOutput("sa_sts_abt", sts_abt, 1);
    checkOutput("sa_cts_str", cts_str, cStart);

    // Start while running is ignored, then reset mid-HOLD
    cfg_seg = 16'd2;
    cfg_hld = 32'd6;
    c6      = cts;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitAcq(n);
    idle(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rs_acq_rst", ifc.acq_rst, 0);
    checkOutput("rs_run", sts_run, 1);
    checkOutput("rs_cts_str", cts_str, c6);
    idle(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("rs_seg_before", sts_seg, 1);
    idle(2);
    ARESET = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    ARESET = 1'b0;
    checkOutput("mr_run", sts_run, 0);
    checkOutput("mr_acq_rst", ifc.acq_rst, 0);
    checkOutput("mr_acq_acq", ifc.acq_acq, 0);
    checkOutput("mr_acq_stp", ifc.acq_stp, 0);
    checkOutput("mr_seg", sts_seg, 0);
    checkOutput("mr_cts_str", cts_str, 0);
    checkOutput("mr_cts_end", cts_end, 0);
    checkOutput("mr_irq_don", irq_don, 0);
    idle(6);
    checkOutput("mr_stays_idle", sts_run, 0);

`ifdef ACQ_SEQ_TMO_EN
    // Timeout forces a stop after 8 WAIT cycles; echoed stop ends the segment
    cfg_seg = 16'd2;
    cfg_hld = 32'd0;
    cfg_tmo = 32'd8;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("tmo_clear", sts_tmo, 0);
    waitAcq(n);
    n = 0;
    while (ifc.acq_stp !== 1'b1 && n < 50) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("tmo_delay", n, 9);
    checkOutput("tmo_sticky", sts_tmo, 1);
    checkOutput("tmo_run", sts_run, 1);
    checkOutput("tmo_acq", ifc.acq_acq, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("tmo_seg", sts_seg, 1);
    checkOutput("tmo_rearm", ifc.acq_acq, 1);
    checkOutput("tmo_stp_pulse", ifc.acq_stp, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("tmo_end_run", sts_run, 0);
    checkOutput("tmo_end_sticky", sts_tmo, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
